// File: rtl/mouse_input_if.sv
// Bundles the mouse button and position signals shared by mouse_input
// and whatever drives it. Clock and reset stay plain ports on the module.
interface mouse_input_if;
  logic        button_raw_;
  logic        delta_valid;
  logic [7:0]  delta_x;
  logic        recenter;
  logic        mouse_pressed_;
  logic [15:0] mouse_x;
  logic        press_event;

  // Driver side: produces raw button, deltas and strobes, observes results
  modport master (
    output button_raw_, delta_valid, delta_x, recenter,
    input  mouse_pressed_, mouse_x, press_event
  );

  // Design side: consumes raw inputs, produces debounced button and position
  modport slave (
    input  button_raw_, delta_valid, delta_x, recenter,
    output mouse_pressed_, mouse_x, press_event
  );
endinterface

// File: rtl/mouse_input.sv
// Mouse front end: synchronizes and debounces an active-low button, and
// integrates signed horizontal deltas into a saturating absolute X position.
// The button and position paths share only the clock and reset.
module mouse_input #(
  parameter int          DEBOUNCE_CYCLES = 16,
  parameter logic [15:0] X_MAX           = 16'd639
) (
  input  logic          clock,
  input  logic          reset_,
  mouse_input_if.slave  bus
);

  typedef enum logic [1:0] {
    RELEASED        = 2'd0,
    CONFIRM_PRESS   = 2'd1,
    PRESSED         = 2'd2,
    CONFIRM_RELEASE = 2'd3
  } state_e;

  // Counter value at which a confirmation is accepted; using >= lets a
  // DEBOUNCE_CYCLES of 1 leave the confirm state after a single cycle.
  localparam logic [7:0]  CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0] X_MID    = X_MAX >> 1;

  logic [1:0]         sync_q, sync_d;
  logic               btn_s;
  state_e             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               pressed_q, pressed_d;
  logic               press_q, press_d;
  logic [15:0]        x_q, x_d;
  logic signed [17:0] sum_s;
  logic signed [17:0] x_max_s;

  assign btn_s = sync_q[1];

  // Two-flop synchronizer input: shift the raw button toward btn_s
  always_comb begin
    sync_d = {sync_q[0], bus.button_raw_};
  end

  // Debounce FSM next state, counter and registered button outputs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RELEASED: begin
        if (btn_s == 1'b0) begin
          state_d = CONFIRM_PRESS;
          cnt_d   = 8'd1;
        end else begin
          state_d = RELEASED;
        end
      end
      CONFIRM_PRESS: begin
        if (btn_s == 1'b1) begin
          state_d = RELEASED;
          cnt_d   = 8'd0;
        end else if (cnt_q >= CNT_LAST) begin
          state_d = PRESSED;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      PRESSED: begin
        if (btn_s == 1'b1) begin
          state_d = CONFIRM_RELEASE;
          cnt_d   = 8'd1;
        end else begin
          state_d = PRESSED;
        end
      end
      CONFIRM_RELEASE: begin
        if (btn_s == 1'b0) begin
          state_d = PRESSED;
          cnt_d   = 8'd0;
        end else if (cnt_q >= CNT_LAST) begin
          state_d = RELEASED;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = 8'd0;
      end
    endcase
    pressed_d = ~((state_d == PRESSED) || (state_d == CONFIRM_RELEASE));
    press_d   = (state_q == CONFIRM_PRESS) && (state_d == PRESSED);
  end

  // Position update: 18-bit signed sum so no wrap occurs before clamping
  always_comb begin
    x_max_s = $signed({2'b00, X_MAX});
    sum_s   = $signed({2'b00, x_q}) + $signed({{10{bus.delta_x[7]}}, bus.delta_x});
    x_d     = x_q;
    if (bus.recenter) begin
      x_d = X_MID;
    end else if (bus.delta_valid) begin
      if (sum_s < 18'sd0) begin
        x_d = 16'd0;
      end else if (sum_s > x_max_s) begin
        x_d = X_MAX;
      end else begin
        x_d = sum_s[15:0];
      end
    end else begin
      x_d = x_q;
    end
  end

  // State register for synchronizer, debounce FSM and position
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      sync_q    <= 2'b11;
      state_q   <= RELEASED;
      cnt_q     <= 8'd0;
      pressed_q <= 1'b1;
      press_q   <= 1'b0;
      x_q       <= 16'd0;
    end else begin
      sync_q    <= sync_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pressed_q <= pressed_d;
      press_q   <= press_d;
      x_q       <= x_d;
    end
  end

  assign bus.mouse_pressed_ = pressed_q;
  assign bus.press_event    = press_q;
  assign bus.mouse_x        = x_q;

endmodule

// File: tb/tb_mouse_input.sv
// Self-checking bench for mouse_input: expected press-event cycles and
// expected positions are queued when stimulus is driven and compared when
// the design produces them.
module tb_mouse_input;

  logic clock;
  logic reset_;
  int   cyc;
  int   n_checks;
  int   n_pass;
  int   model_x;
  int   rel;
  int   press_exp_q[$];
  int   pos_exp_q[$];

  mouse_input_if bus ();

  mouse_input #(
    .DEBOUNCE_CYCLES (16),
    .X_MAX           (16'd639)
  ) dut (
    .clock  (clock),
    .reset_ (reset_),
    .bus    (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Count rising edges so press timing can be checked in edges
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int clamp_x(input int cur, input int d);
    int s;
    s = cur + d;
    if (s < 0) return 0;
    if (s > 639) return 639;
    return s;
  endfunction

  // Press-event monitor: pops the expected cycle of each press
  always @(negedge clock) begin
    if (reset_ && bus.press_event) begin
      if (press_exp_q.size() == 0) begin
        check_val("press_extra", int'(bus.press_event), 0);
      end else begin
        check_val("press_cyc", cyc, press_exp_q.pop_front());
      end
    end
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clock);
  endtask

  // One-cycle strobe; expected position queued now, compared after the edge
  task automatic drive_pos(input bit rc, input bit dv, input int d);
    bus.recenter    = rc;
    bus.delta_valid = dv;
    bus.delta_x     = 8'(d);
    if (rc) model_x = 319;
    else if (dv) model_x = clamp_x(model_x, d);
    pos_exp_q.push_back(model_x);
    @(negedge clock);
    bus.recenter    = 1'b0;
    bus.delta_valid = 1'b0;
    check_val("mouse_x", int'(bus.mouse_x), pos_exp_q.pop_front());
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    cyc = 0; n_checks = 0; n_pass = 0; model_x = 0;
    reset_          = 1'b0;
    bus.button_raw_ = 1'b0;
    bus.delta_valid = 1'b1;
    bus.delta_x     = 8'd50;
    bus.recenter    = 1'b1;
    wait_n(3);
    // Strobes during reset are ignored
    check_val("rst_mouse_x", int'(bus.mouse_x), 0);
    check_val("rst_pressed", int'(bus.mouse_pressed_), 1);
    check_val("rst_press_ev", int'(bus.press_event), 0);
    bus.delta_valid = 1'b0;
    bus.recenter    = 1'b0;

    // Button held low from the start: press at edge 18 after release
    reset_ = 1'b1;
    rel = cyc;
    press_exp_q.push_back(rel + 18);
    wait_n(17);
    check_val("lat_edge17", int'(bus.mouse_pressed_), 1);
    wait_n(1);
    check_val("lat_edge18", int'(bus.mouse_pressed_), 0);
    check_val("x_after_rst", int'(bus.mouse_x), 0);
    wait_n(3);

    // Short release bounce while pressed leaves the button pressed
    bus.button_raw_ = 1'b1;
    wait_n(5);
    bus.button_raw_ = 1'b0;
    wait_n(25);
    check_val("rel_bounce", int'(bus.mouse_pressed_), 0);

    // Clean release
    bus.button_raw_ = 1'b1;
    wait_n(25);
    check_val("released", int'(bus.mouse_pressed_), 1);

    // Low 10, high 3, low 20: one press 18 edges after last fall,
    // with position moving concurrently
    bus.button_raw_ = 1'b0;
    wait_n(10);
    check_val("bounce_hold", int'(bus.mouse_pressed_), 1);
    bus.button_raw_ = 1'b1;
    wait_n(3);
    bus.button_raw_ = 1'b0;
    rel = cyc;
    press_exp_q.push_back(rel + 18);
    for (int i = 0; i < 3; i++) drive_pos(1'b0, 1'b1, 20);
    wait_n(14);
    check_val("bounce_edge17", int'(bus.mouse_pressed_), 1);
    wait_n(1);
    check_val("bounce_edge18", int'(bus.mouse_pressed_), 0);
    wait_n(2);
    bus.button_raw_ = 1'b1;
    wait_n(25);

    // Position: saturate low, then 5, -8 -> 0, then +127 steps to 639
    drive_pos(1'b0, 1'b1, -128);
    drive_pos(1'b0, 1'b1, 5);
    drive_pos(1'b0, 1'b1, -8);
    for (int i = 0; i < 6; i++) drive_pos(1'b0, 1'b1, 127);
    drive_pos(1'b0, 1'b1, 127);
    // Hold with no strobes
    wait_n(3);
    check_val("x_hold", int'(bus.mouse_x), 639);
    for (int i = 0; i < 5; i++) drive_pos(1'b0, 1'b1, -128);
    // Recenter beats a simultaneous delta
    drive_pos(1'b1, 1'b1, 10);
    drive_pos(1'b0, 1'b1, -19);

    // Press, then reset pulse mid-press with button still low
    bus.button_raw_ = 1'b0;
    rel = cyc;
    press_exp_q.push_back(rel + 18);
    wait_n(20);
    check_val("pre_rst_press", int'(bus.mouse_pressed_), 0);
    reset_ = 1'b0;
    #1;
    check_val("async_pressed", int'(bus.mouse_pressed_), 1);
    check_val("async_mouse_x", int'(bus.mouse_x), 0);
    model_x = 0;
    @(negedge clock);
    reset_ = 1'b1;
    rel = cyc;
    press_exp_q.push_back(rel + 18);
    wait_n(17);
    check_val("rerst_edge17", int'(bus.mouse_pressed_), 1);
    wait_n(1);
    check_val("rerst_edge18", int'(bus.mouse_pressed_), 0);
    wait_n(3);
    drive_pos(1'b0, 1'b1, 100);

    check_val("press_missing", press_exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
